// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared encodings, scoreboard entry type and helpers for hazard_ctrl
//
// Contents:
//   RES_*       result-source encodings of d_res
//   FWD_*       D-stage forward-select encodings
//   sb_entry_t  one in-flight register write (wr, wa, tnew)
//   init_tnew   cycles until a fresh producer's result exists, by result source
//   age_entry   one-stage advance of an entry, tnew saturating at 0
package hazard_pkg;

    localparam logic [1:0] RES_NONE = 2'b00;
    localparam logic [1:0] RES_ALU  = 2'b01;
    localparam logic [1:0] RES_DM   = 2'b10;
    localparam logic [1:0] RES_PC   = 2'b11;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_E  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;
    localparam logic [1:0] FWD_W  = 2'b11;

    typedef struct packed {
        logic       wr;
        logic [4:0] wa;
        logic [1:0] tnew;
    } sb_entry_t;

    // Link values (PC) are known at decode, so they are ready immediately.
    function automatic logic [1:0] init_tnew(input logic [1:0] res);
        logic [1:0] t;
        case (res)
            RES_ALU: t = 2'd1;
            RES_DM:  t = 2'd2;
            default: t = 2'd0;
        endcase
        return t;
    endfunction

    function automatic sb_entry_t age_entry(input sb_entry_t e);
        sb_entry_t a;
        a = e;
        if (e.tnew != 2'd0) begin
            a.tnew = e.tnew - 2'd1;
        end
        return a;
    endfunction

endpackage

// File: rtl/hazard_src_check.sv
// rtl/hazard_src_check.sv - per-source hazard check against the E/M/W scoreboard
//
// Ports:
//   src      in  5   source register number
//   use_src  in  1   source is actually read
//   tuse     in  2   cycles until the value is needed
//   ent_e/m/w in sb_entry_t  scoreboard entries, E is the youngest
//   stall    out 1   nearest producer not ready in time
//   fwd_sel  out 2   stage to forward from (FWD_RF when not forwardable now)
import hazard_pkg::*;

module hazard_src_check (
    input  logic [4:0] src,
    input  logic       use_src,
    input  logic [1:0] tuse,
    input  sb_entry_t  ent_e,
    input  sb_entry_t  ent_m,
    input  sb_entry_t  ent_w,
    output logic       stall,
    output logic [1:0] fwd_sel
);

    logic       hit;
    logic [1:0] hit_tnew;
    logic [1:0] hit_stage;
    logic       match_e;
    logic       match_m;
    logic       match_w;
    logic       src_live;

    // $0 is hardwired, so a read of it never depends on a producer.
    assign src_live = use_src && (src != 5'd0);
    assign match_e  = src_live && ent_e.wr && (ent_e.wa == src);
    assign match_m  = src_live && ent_m.wr && (ent_m.wa == src);
    assign match_w  = src_live && ent_w.wr && (ent_w.wa == src);

    // Youngest producer wins; older writes to the same register are stale.
    always_comb begin
        hit       = 1'b0;
        hit_tnew  = 2'd0;
        hit_stage = FWD_RF;
        if (match_e) begin
            hit       = 1'b1;
            hit_tnew  = ent_e.tnew;
            hit_stage = FWD_E;
        end else if (match_m) begin
            hit       = 1'b1;
            hit_tnew  = ent_m.tnew;
            hit_stage = FWD_M;
        end else if (match_w) begin
            hit       = 1'b1;
            hit_tnew  = ent_w.tnew;
            hit_stage = FWD_W;
        end
    end

    assign stall   = hit && (hit_tnew > tuse);
    assign fwd_sel = (hit && (hit_tnew == 2'd0)) ? hit_stage : FWD_RF;

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall/forward controller with E/M/W write scoreboard and stall counter
//
// Ports:
//   clk, reset              clock; asynchronous active-high reset
//   freeze                  global hold of scoreboard and counter
//   d_rs, d_rt              D-stage source registers
//   d_use_rs, d_use_rt      source is read
//   d_tuse_rs, d_tuse_rt    cycles until source is needed
//   d_regwrite, d_wa, d_res D-stage destination and result source
//   stall                   hold F/D, bubble into E
//   fwd_rs_sel, fwd_rt_sel  D-stage forward source
//   stall_cnt               saturating count of stalled cycles
import hazard_pkg::*;

module hazard_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        freeze,
    input  logic [4:0]  d_rs,
    input  logic [4:0]  d_rt,
    input  logic        d_use_rs,
    input  logic        d_use_rt,
    input  logic [1:0]  d_tuse_rs,
    input  logic [1:0]  d_tuse_rt,
    input  logic        d_regwrite,
    input  logic [4:0]  d_wa,
    input  logic [1:0]  d_res,
    output logic        stall,
    output logic [1:0]  fwd_rs_sel,
    output logic [1:0]  fwd_rt_sel,
    output logic [31:0] stall_cnt
);

    sb_entry_t   e_q, e_d;
    sb_entry_t   m_q, m_d;
    sb_entry_t   w_q, w_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic        rs_stall;
    logic        rt_stall;

    hazard_src_check u_rs_check (
        .src     (d_rs),
        .use_src (d_use_rs),
        .tuse    (d_tuse_rs),
        .ent_e   (e_q),
        .ent_m   (m_q),
        .ent_w   (w_q),
        .stall   (rs_stall),
        .fwd_sel (fwd_rs_sel)
    );

    hazard_src_check u_rt_check (
        .src     (d_rt),
        .use_src (d_use_rt),
        .tuse    (d_tuse_rt),
        .ent_e   (e_q),
        .ent_m   (m_q),
        .ent_w   (w_q),
        .stall   (rt_stall),
        .fwd_sel (fwd_rt_sel)
    );

    // A frozen pipeline does not advance, so it cannot be stalling either.
    assign stall     = (rs_stall || rt_stall) && !freeze;
    assign stall_cnt = stall_cnt_q;

    always_comb begin
        e_d         = e_q;
        m_d         = m_q;
        w_d         = w_q;
        stall_cnt_d = stall_cnt_q;
        if (!freeze) begin
            if (stall) begin
                e_d = '0;
            end else begin
                e_d.wr   = d_regwrite && (d_wa != 5'd0);
                e_d.wa   = d_wa;
                e_d.tnew = init_tnew(d_res);
            end
            m_d = age_entry(e_q);
            w_d = age_entry(m_q);
            if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_d = stall_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_q         <= '0;
            m_q         <= '0;
            w_q         <= '0;
            stall_cnt_q <= 32'd0;
        end else begin
            e_q         <= e_d;
            m_q         <= m_d;
            w_q         <= w_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard testbench for hazard_ctrl with directed vectors
import hazard_pkg::*;

module tb_hazard_ctrl;

    logic        clk;
    logic        reset;
    logic        freeze;
    logic [4:0]  d_rs;
    logic [4:0]  d_rt;
    logic        d_use_rs;
    logic        d_use_rt;
    logic [1:0]  d_tuse_rs;
    logic [1:0]  d_tuse_rt;
    logic        d_regwrite;
    logic [4:0]  d_wa;
    logic [1:0]  d_res;
    logic        stall;
    logic [1:0]  fwd_rs_sel;
    logic [1:0]  fwd_rt_sel;
    logic [31:0] stall_cnt;

    typedef struct {
        string       name;
        logic        stall;
        logic [1:0]  frs;
        logic [1:0]  frt;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks;
    int   errors;
    bit   stim_done;

    hazard_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .freeze     (freeze),
        .d_rs       (d_rs),
        .d_rt       (d_rt),
        .d_use_rs   (d_use_rs),
        .d_use_rt   (d_use_rt),
        .d_tuse_rs  (d_tuse_rs),
        .d_tuse_rt  (d_tuse_rt),
        .d_regwrite (d_regwrite),
        .d_wa       (d_wa),
        .d_res      (d_res),
        .stall      (stall),
        .fwd_rs_sel (fwd_rs_sel),
        .fwd_rt_sel (fwd_rt_sel),
        .stall_cnt  (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic expect_out(input string name, input logic s, input logic [1:0] frs,
                              input logic [1:0] frt, input logic [31:0] cnt);
        exp_t e;
        e.name  = name;
        e.stall = s;
        e.frs   = frs;
        e.frt   = frt;
        e.cnt   = cnt;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic [4:0] rs, input logic urs, input logic [1:0] trs,
                         input logic [4:0] rt, input logic urt, input logic [1:0] trt,
                         input logic rw, input logic [4:0] wa, input logic [1:0] res);
        d_rs       = rs;
        d_use_rs   = urs;
        d_tuse_rs  = trs;
        d_rt       = rt;
        d_use_rt   = urt;
        d_tuse_rt  = trt;
        d_regwrite = rw;
        d_wa       = wa;
        d_res      = res;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input string fld, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s.%s got=%0h expected=%0h", name, fld, got, want);
        end
    endtask

    // Monitor: samples mid-cycle, and also right after an asynchronous reset edge.
    initial begin
        exp_t e;
        int   drain;
        drain = 0;
        forever begin
            @(negedge clk or posedge reset);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk(e.name, "stall", {31'd0, stall}, {31'd0, e.stall});
                chk(e.name, "fwd_rs", {30'd0, fwd_rs_sel}, {30'd0, e.frs});
                chk(e.name, "fwd_rt", {30'd0, fwd_rt_sel}, {30'd0, e.frt});
                chk(e.name, "stall_cnt", stall_cnt, e.cnt);
            end else if (stim_done) begin
                break;
            end
            if (stim_done) drain++;
            if (drain > 10) begin
                errors++;
                $display("FAIL drain pending=%0d expected=0", exp_q.size());
                break;
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        checks    = 0;
        errors    = 0;
        stim_done = 1'b0;
        reset     = 1'b1;
        freeze    = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, RES_NONE);
        tick();
        expect_out("reset_state", 0, FWD_RF, FWD_RF, 0);
        tick();
        reset = 1'b0;

        // lw $1 then beq $1,$2
        drive(0, 0, 0, 0, 0, 0, 1, 1, RES_DM);   expect_out("lw1", 0, FWD_RF, FWD_RF, 0); tick();
        drive(1, 1, 0, 2, 1, 0, 0, 0, RES_NONE); expect_out("beq_s1", 1, FWD_RF, FWD_RF, 0); tick();
        expect_out("beq_s2", 1, FWD_RF, FWD_RF, 1); tick();
        expect_out("beq_go", 0, FWD_W, FWD_RF, 2); tick();

        // lw $5 then addu $7,$5,$6
        drive(0, 0, 0, 0, 0, 0, 1, 5, RES_DM);   expect_out("lw5", 0, FWD_RF, FWD_RF, 2); tick();
        drive(5, 1, 1, 6, 1, 1, 1, 7, RES_ALU);  expect_out("addu_s", 1, FWD_RF, FWD_RF, 2); tick();
        expect_out("addu_go", 0, FWD_RF, FWD_RF, 3); tick();

        // jal then jr $31 (rs==rt to exercise both selects identically)
        drive(0, 0, 0, 0, 0, 0, 1, 31, RES_PC);  expect_out("jal", 0, FWD_RF, FWD_RF, 3); tick();
        drive(31, 1, 0, 31, 1, 0, 0, 0, RES_NONE); expect_out("jr", 0, FWD_E, FWD_E, 3); tick();

        // lw $3 then addu $3: E shadows M; rt reads $31 from W
        drive(0, 0, 0, 0, 0, 0, 1, 3, RES_DM);   expect_out("lw3", 0, FWD_RF, FWD_RF, 3); tick();
        drive(8, 1, 1, 31, 1, 1, 1, 3, RES_ALU); expect_out("addu3_w31", 0, FWD_RF, FWD_W, 3); tick();
        drive(3, 1, 1, 0, 1, 0, 1, 0, RES_ALU);  expect_out("shadow_e", 0, FWD_RF, FWD_RF, 3); tick();
        drive(0, 1, 0, 3, 1, 0, 0, 0, RES_NONE); expect_out("zero_and_m", 0, FWD_RF, FWD_M, 3); tick();

        // freeze while lw $9 sits in E
        drive(0, 0, 0, 0, 0, 0, 1, 9, RES_DM);   expect_out("lw9", 0, FWD_RF, FWD_RF, 3); tick();
        drive(9, 1, 0, 0, 0, 0, 0, 0, RES_NONE);
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            expect_out("frozen", 0, FWD_RF, FWD_RF, 3);
            tick();
        end
        freeze = 1'b0;
        expect_out("thaw_s1", 1, FWD_RF, FWD_RF, 3); tick();
        expect_out("thaw_s2", 1, FWD_RF, FWD_RF, 4); tick();
        expect_out("thaw_go", 0, FWD_W, FWD_RF, 5); tick();

        // build up to stall_cnt=7 and reset during a stall
        drive(0, 0, 0, 0, 0, 0, 1, 10, RES_DM);  expect_out("lw10", 0, FWD_RF, FWD_RF, 5); tick();
        drive(10, 1, 0, 0, 0, 0, 0, 0, RES_NONE); expect_out("beq10_s1", 1, FWD_RF, FWD_RF, 5); tick();
        expect_out("beq10_s2", 1, FWD_RF, FWD_RF, 6); tick();
        drive(0, 0, 0, 0, 0, 0, 1, 11, RES_DM);  expect_out("lw11", 0, FWD_RF, FWD_RF, 7); tick();
        drive(11, 1, 0, 0, 0, 0, 0, 0, RES_NONE); expect_out("beq11_s", 1, FWD_RF, FWD_RF, 7);
        @(negedge clk);
        #2;
        expect_out("reset_mid_stall", 0, FWD_RF, FWD_RF, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        expect_out("after_reset", 0, FWD_RF, FWD_RF, 0);
        tick();
        stim_done = 1'b1;
    end

endmodule
